inst_fetch_ctrl: RTL and testbench

Owns the bus of the byte-programmed instruction memory. It sits between the serial programming byte stream / core control on one side and the instruction memory on the other. In LOAD mode it writes an incoming byte stream into consecutive memory bytes. In RUN mode it generates the PC, reads 32-bit little-endian words, and presents them to decode over a valid/ready handshake.

---
 rtl/inst_pkg.sv | 16 +
 rtl/prog_loader.sv | 83 ++++++++
 rtl/inst_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared constants and state encoding for the instruction fetch controller.
package inst_pkg;
  localparam int PC_BITS   = 8;
  localparam int MEM_DEPTH = 128;
  localparam int INST_WORD = 32;
  localparam int BYTE_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FETCH = 3'd3,
    ST_HOLD  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;
endpackage

// File: rtl/prog_loader.sv
// LOAD/WRITE sequencing: write pointer, latched byte and optional running checksum.
// Define LOAD_CHECKSUM_EN to build the modulo-256 checksum of accepted bytes.
module prog_loader
  import inst_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  state_t               state,
  input  logic                 load_start,
  input  logic                 load_done,
  input  logic [BYTE_SIZE-1:0] prog_byte,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 write_en,
  output logic [PC_BITS-1:0]   ptr,
  output logic [BYTE_SIZE-1:0] byte_q,
  output logic [BYTE_SIZE-1:0] checksum,
  output state_t               next_state
);

  logic accept;
  logic done_pend;
  logic ptr_last;

  assign byte_ready = (state == ST_LOAD);
  assign write_en   = (state == ST_WRITE);
  assign accept     = byte_ready && byte_valid;
  assign ptr_last   = (ptr == PC_BITS'(MEM_DEPTH - 1));

  // A load_done arriving with the accepted byte is remembered so the load ends after its write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      byte_q    <= '0;
      done_pend <= 1'b0;
    end else if (load_start) begin
      ptr       <= '0;
      done_pend <= 1'b0;
    end else begin
      if (accept) begin
        byte_q    <= prog_byte;
        done_pend <= load_done;
      end
      if (write_en) begin
        ptr       <= ptr + PC_BITS'(1);
        done_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state = state;
    if (state == ST_LOAD) begin
      if (accept)
        next_state = ST_WRITE;
      else if (load_done)
        next_state = ST_IDLE;
    end else if (state == ST_WRITE) begin
      if (done_pend || load_done || ptr_last)
        next_state = ST_IDLE;
      else
        next_state = ST_LOAD;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [BYTE_SIZE-1:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum <= '0;
    else if (load_start)
      sum <= '0;
    else if (accept)
      sum <= sum + prog_byte;
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction memory bus owner: byte-stream programming in LOAD, PC-driven word fetch in RUN.
// Optional feature macro: LOAD_CHECKSUM_EN (see prog_loader).
module inst_fetch_ctrl
  import inst_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load_start,
  input  logic                 i_load_done,
  input  logic [BYTE_SIZE-1:0] i_byte,
  input  logic                 i_byte_valid,
  output logic                 o_byte_ready,
  input  logic                 i_run,
  input  logic                 i_branch_valid,
  input  logic [PC_BITS-1:0]   i_branch_target,
  output logic [PC_BITS-1:0]   o_mem_addr,
  output logic [BYTE_SIZE-1:0] o_mem_data,
  output logic                 o_mem_cs,
  input  logic [INST_WORD-1:0] i_mem_rdata,
  output logic [INST_WORD-1:0] o_instr,
  output logic                 o_instr_valid,
  input  logic                 i_instr_ready,
  output logic [PC_BITS-1:0]   o_pc,
  output logic [PC_BITS-1:0]   o_load_count,
  output logic                 o_loading,
  output logic                 o_fault,
  output logic [BYTE_SIZE-1:0] o_checksum
);

  localparam logic [PC_BITS-1:0] LAST_FETCH = PC_BITS'(MEM_DEPTH - 4);
  localparam logic [PC_BITS-1:0] WORD_MASK  = {{(PC_BITS-2){1'b1}}, 2'b00};

  state_t               state;
  state_t               load_next;
  logic [PC_BITS-1:0]   pc;
  logic [PC_BITS-1:0]   ptr;
  logic [BYTE_SIZE-1:0] byte_q;
  logic                 write_en;
  logic                 in_load;

  prog_loader u_loader (
    .clk        (i_clk),
    .rst        (i_rst),
    .state      (state),
    .load_start (i_load_start),
    .load_done  (i_load_done),
    .prog_byte  (i_byte),
    .byte_valid (i_byte_valid),
    .byte_ready (o_byte_ready),
    .write_en   (write_en),
    .ptr        (ptr),
    .byte_q     (byte_q),
    .checksum   (o_checksum),
    .next_state (load_next)
  );

  // Loader owns the address bus only while programming; otherwise the PC drives it.
  assign in_load      = (state == ST_LOAD) || (state == ST_WRITE);
  assign o_mem_addr   = in_load ? ptr : pc;
  assign o_mem_data   = byte_q;
  assign o_mem_cs     = write_en;
  assign o_load_count = ptr;
  assign o_loading    = (state == ST_LOAD);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      pc            <= '0;
      o_instr       <= '0;
      o_pc          <= '0;
      o_instr_valid <= 1'b0;
      o_fault       <= 1'b0;
    end else if (i_load_start) begin
      state         <= ST_LOAD;
      pc            <= '0;
      o_instr_valid <= 1'b0;
      o_fault       <= 1'b0;
    end else begin
      case (state)
        ST_LOAD, ST_WRITE: state <= load_next;
        ST_IDLE: if (i_run) state <= ST_FETCH;
        ST_FETCH: begin
          if (!i_run) begin
            state <= ST_IDLE;
          end else if (pc > LAST_FETCH) begin
            state   <= ST_FAULT;
            o_fault <= 1'b1;
          end else begin
            o_instr       <= i_mem_rdata;
            o_pc          <= pc;
            o_instr_valid <= 1'b1;
            state         <= ST_HOLD;
          end
        end
        // A redirect flushes the held instruction even if decode accepts it this cycle.
        ST_HOLD: begin
          if (i_branch_valid) begin
            o_instr_valid <= 1'b0;
            pc            <= i_branch_target & WORD_MASK;
            state         <= ST_FETCH;
          end else if (i_instr_ready) begin
            o_instr_valid <= 1'b0;
            pc            <= pc + PC_BITS'(4);
            state         <= ST_FETCH;
          end
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with a byte-wide memory model.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loadStart = 1'b0;
  logic        loadDone = 1'b0;
  logic [7:0]  progByte = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        run = 1'b0;
  logic        branchValid = 1'b0;
  logic [7:0]  branchTarget = 8'h00;
  logic [7:0]  memAddr;
  logic [7:0]  memData;
  logic        memCs;
  logic [31:0] memRdata;
  logic [31:0] instr;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [7:0]  pc;
  logic [7:0]  loadCount;
  logic        loading;
  logic        fault;
  logic [7:0]  checksum;

  logic [7:0]  mem [0:127];
  int          nChecks = 0;
  int          nFails = 0;
  logic [7:0]  progBytes [0:7] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h10, 8'h00};
  logic [7:0]  expSum;

  inst_fetch_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_load_start    (loadStart),
    .i_load_done     (loadDone),
    .i_byte          (progByte),
    .i_byte_valid    (byteValid),
    .o_byte_ready    (byteReady),
    .i_run           (run),
    .i_branch_valid  (branchValid),
    .i_branch_target (branchTarget),
    .o_mem_addr      (memAddr),
    .o_mem_data      (memData),
    .o_mem_cs        (memCs),
    .i_mem_rdata     (memRdata),
    .o_instr         (instr),
    .o_instr_valid   (instrValid),
    .i_instr_ready   (instrReady),
    .o_pc            (pc),
    .o_load_count    (loadCount),
    .o_loading       (loading),
    .o_fault         (fault),
    .o_checksum      (checksum)
  );

  always #5 clk = ~clk;

  // Memory preloaded with mem[i] = i so fetched words beyond the program are recognisable.
  initial for (int i = 0; i < 128; i++) mem[i] = 8'(i);

  always @(posedge clk) if (memCs && memAddr < 8'd128) mem[memAddr[6:0]] <= memData;

  function automatic logic [7:0] rdByte(input logic [7:0] a);
    return (a < 8'd128) ? mem[a[6:0]] : 8'h00;
  endfunction

  assign memRdata = {rdByte(memAddr + 8'd3), rdByte(memAddr + 8'd2),
                     rdByte(memAddr + 8'd1), rdByte(memAddr)};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic loadByte(input logic [7:0] b, input logic last, input int idx);
    progByte  = b;
    byteValid = 1'b1;
    loadDone  = last;
    applyStimulus(1);
    checkOutput($sformatf("wr_cs%0d", idx), 32'(memCs), 32'd1);
    checkOutput($sformatf("wr_addr%0d", idx), 32'(memAddr), 32'(idx));
    checkOutput($sformatf("wr_data%0d", idx), 32'(memData), 32'(b));
    checkOutput($sformatf("wr_rdy%0d", idx), 32'(byteReady), 32'd0);
    byteValid = 1'b0;
    loadDone  = 1'b0;
    applyStimulus(1);
    checkOutput($sformatf("post_cs%0d", idx), 32'(memCs), 32'd0);
    checkOutput($sformatf("count%0d", idx), 32'(loadCount), 32'(idx + 1));
    checkOutput($sformatf("loading%0d", idx), 32'(loading), last ? 32'd0 : 32'd1);
  endtask

  task automatic startLoad();
    loadStart = 1'b1;
    applyStimulus(1);
    loadStart = 1'b0;
  endtask

  task automatic checkHold(input string tag, input logic [7:0] expPc, input logic [31:0] expInstr);
    checkOutput({tag, "_valid"}, 32'(instrValid), 32'd1);
    checkOutput({tag, "_pc"}, 32'(pc), 32'(expPc));
    checkOutput({tag, "_instr"}, instr, expInstr);
    checkOutput({tag, "_cs"}, 32'(memCs), 32'd0);
  endtask

  initial begin
    applyStimulus(2);
    rst = 1'b0;
    checkOutput("rst_cs", 32'(memCs), 32'd0);
    checkOutput("rst_valid", 32'(instrValid), 32'd0);
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_loading", 32'(loading), 32'd0);
    checkOutput("rst_ready", 32'(byteReady), 32'd0);
    checkOutput("rst_count", 32'(loadCount), 32'd0);
    checkOutput("rst_sum", 32'(checksum), 32'd0);

    // Program 8 bytes; the last byte arrives together with load_done.
    startLoad();
    checkOutput("load_loading", 32'(loading), 32'd1);
    checkOutput("load_ready", 32'(byteReady), 32'd1);
    for (int k = 0; k < 8; k++) loadByte(progBytes[k], k == 7, k);
    checkOutput("load_count", 32'(loadCount), 32'd8);
`ifdef LOAD_CHECKSUM_EN
    expSum = 8'hB7;
`else
    expSum = 8'h00;
`endif
    checkOutput("load_sum", 32'(checksum), 32'(expSum));

    run = 1'b1;
    instrReady = 1'b1;
    applyStimulus(1);
    checkOutput("fetch_valid0", 32'(instrValid), 32'd0);
    applyStimulus(1);
    checkHold("i0", 8'h00, 32'h0000_0013);
    applyStimulus(1);
    checkOutput("fetch_valid1", 32'(instrValid), 32'd0);
    applyStimulus(1);
    checkHold("i1", 8'h04, 32'h0010_0193);

    instrReady = 1'b0;
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1);
      checkHold($sformatf("stall%0d", s), 8'h04, 32'h0010_0193);
    end

    branchValid = 1'b1;
    branchTarget = 8'h0A;
    applyStimulus(1);
    branchValid = 1'b0;
    checkOutput("br_flush", 32'(instrValid), 32'd0);
    applyStimulus(1);
    checkHold("br_tgt", 8'h08, 32'h0B0A_0908);

    branchValid = 1'b1;
    branchTarget = 8'h7E;
    applyStimulus(1);
    branchValid = 1'b0;
    applyStimulus(1);
    checkHold("edge", 8'h7C, 32'h7F7E_7D7C);
    instrReady = 1'b1;
    applyStimulus(1);
    checkOutput("edge_flush", 32'(instrValid), 32'd0);
    checkOutput("edge_addr", 32'(memAddr), 32'h80);
    applyStimulus(1);
    instrReady = 1'b0;
    checkOutput("fault_set", 32'(fault), 32'd1);
    checkOutput("fault_valid", 32'(instrValid), 32'd0);
    applyStimulus(2);
    checkOutput("fault_hold", 32'(fault), 32'd1);
    checkOutput("fault_valid2", 32'(instrValid), 32'd0);
    checkOutput("fault_cs", 32'(memCs), 32'd0);

    run = 1'b0;
    startLoad();
    checkOutput("reload_fault", 32'(fault), 32'd0);
    checkOutput("reload_count", 32'(loadCount), 32'd0);
    checkOutput("reload_sum", 32'(checksum), 32'd0);
    checkOutput("reload_loading", 32'(loading), 32'd1);
    loadByte(8'hFF, 1'b0, 0);
    loadByte(8'h02, 1'b1, 1);
`ifdef LOAD_CHECKSUM_EN
    expSum = 8'h01;
`else
    expSum = 8'h00;
`endif
    checkOutput("sum2", 32'(checksum), 32'(expSum));

    startLoad();
    loadDone = 1'b1;
    applyStimulus(1);
    loadDone = 1'b0;
    checkOutput("done_idle", 32'(loading), 32'd0);
    checkOutput("done_count", 32'(loadCount), 32'd0);
    checkOutput("done_cs", 32'(memCs), 32'd0);

    // Asynchronous reset in the middle of a write strobe.
    startLoad();
    progByte = 8'h55;
    byteValid = 1'b1;
    applyStimulus(1);
    byteValid = 1'b0;
    checkOutput("midwr_cs", 32'(memCs), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_cs", 32'(memCs), 32'd0);
    checkOutput("arst_ready", 32'(byteReady), 32'd0);
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("arst_count", 32'(loadCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
